// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants, next-PC source encoding and branch-target
//               table contents for the fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int D_DEF       = 12;
  localparam int LW_DEF      = 6;
  localparam int SD_DEF      = 4;
  localparam int DONE_PC_DEF = 250;

  // The stored table is fixed at 64 entries of 12 bits; fetch_lut adapts it
  // to other index and PC widths.
  localparam int LUT_BITS = 12;
  localparam int LUT_LW   = 6;
  localparam int LUT_N    = 64;

  typedef enum logic [2:0] {
    NPC_INC  = 3'd0,
    NPC_ABS  = 3'd1,
    NPC_REL  = 3'd2,
    NPC_CALL = 3'd3,
    NPC_RET  = 3'd4,
    NPC_HOLD = 3'd5,
    NPC_ZERO = 3'd6
  } npc_sel_t;

  // Entry 1 is -2 (a short backward hop when used relatively); entries from
  // 8 upward are simply 16*index.
  localparam logic [LUT_BITS-1:0] LUT_INIT [LUT_N] = '{
    12'd0,   12'hFFE, 12'd40,  12'd250, 12'd245, 12'd3,   12'd100, 12'hFFF,
    12'd128, 12'd144, 12'd160, 12'd176, 12'd192, 12'd208, 12'd224, 12'd240,
    12'd256, 12'd272, 12'd288, 12'd304, 12'd320, 12'd336, 12'd352, 12'd368,
    12'd384, 12'd400, 12'd416, 12'd432, 12'd448, 12'd464, 12'd480, 12'd496,
    12'd512, 12'd528, 12'd544, 12'd560, 12'd576, 12'd592, 12'd608, 12'd624,
    12'd640, 12'd656, 12'd672, 12'd688, 12'd704, 12'd720, 12'd736, 12'd752,
    12'd768, 12'd784, 12'd800, 12'd816, 12'd832, 12'd848, 12'd864, 12'd880,
    12'd896, 12'd912, 12'd928, 12'd944, 12'd960, 12'd976, 12'd992, 12'd1008
  };

  // Return-stack pointer width: must be able to count 0..depth inclusive.
  function automatic int sp_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_lut.sv
`default_nettype none
// ============================================================================
// Module      : fetch_lut
// Description : Combinational branch/call target table. Maps an LW-bit index
//               from the instruction to a D-bit target (sign-extended or
//               truncated from the 12-bit stored entries).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_lut
  import fetch_pkg::*;
#(
  parameter int D  = D_DEF,
  parameter int LW = LW_DEF
) (
  input  logic [LW-1:0] idx,
  output logic [D-1:0]  target
);

  logic [LUT_LW-1:0] tbl_idx;

  // Fold the instruction index onto the 64-entry stored table.
  generate
    if (LW >= LUT_LW) begin : g_idx_trunc
      assign tbl_idx = idx[LUT_LW-1:0];
    end else begin : g_idx_ext
      assign tbl_idx = {{(LUT_LW-LW){1'b0}}, idx};
    end
  endgenerate

  // Entries are two's complement so relative offsets keep their sign at any D.
  assign target = D'($signed(LUT_INIT[tbl_idx]));

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Program counter sequencer with conditional absolute/relative
//               branches, call/return stack, zero-flag register, sticky
//               program-done detection and sticky stack error.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int D       = D_DEF,
  parameter int LW      = LW_DEF,
  parameter int SD      = SD_DEF,
  parameter int DONE_PC = DONE_PC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          stall,
  input  logic          branch_en,
  input  logic          rel_mode,
  input  logic          call,
  input  logic          ret,
  input  logic [LW-1:0] lut_idx,
  input  logic          flag_we,
  input  logic          flag_in,
  output logic [D-1:0]  prog_ctr,
  output logic          flag_q,
  output logic          done,
  output logic          stack_err
);

  localparam int              SPW      = sp_width(SD);
  localparam int              IW       = (SD > 1) ? $clog2(SD) : 1;
  localparam logic [SPW-1:0]  SP_FULL  = SPW'(SD);
  localparam logic [31:0]     DONE_VAL = 32'(DONE_PC);

  logic [D-1:0]   stack_mem [SD];
  logic [SPW-1:0] sp;
  logic           done_q;

  logic [D-1:0]   lut_target;
  logic [D-1:0]   pc_inc;
  logic [D-1:0]   pc_rel;
  logic [D-1:0]   stack_top;
  logic [D-1:0]   next_pc;
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  top_idx;
  logic           at_done;
  logic           push;
  logic           pop;
  logic           err_set;
  logic           flag_load;
  npc_sel_t       npc_sel;

  fetch_lut #(
    .D  (D),
    .LW (LW)
  ) u_lut (
    .idx    (lut_idx),
    .target (lut_target)
  );

  // Done is visible in the same cycle the PC lands on DONE_PC, then latched.
  assign at_done   = (32'(prog_ctr) == DONE_VAL);
  assign done      = done_q | at_done;

  assign pc_inc    = prog_ctr + D'(1);
  assign pc_rel    = prog_ctr + lut_target;
  assign push_idx  = IW'(sp);
  assign top_idx   = IW'(sp - SPW'(1));
  assign stack_top = stack_mem[top_idx];

  // Priority decode: init > done > stall > call&ret > ret > call > branch > inc.
  always_comb begin
    npc_sel   = NPC_INC;
    push      = 1'b0;
    pop       = 1'b0;
    err_set   = 1'b0;
    flag_load = flag_we & ~stall & ~done & ~init;
    if (init) begin
      npc_sel = NPC_ZERO;
    end else if (done) begin
      npc_sel = NPC_HOLD;
    end else if (stall) begin
      npc_sel = NPC_HOLD;
    end else if (call && ret) begin
      err_set = 1'b1;
    end else if (ret) begin
      if (sp != '0) begin
        npc_sel = NPC_RET;
        pop     = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end else if (call) begin
      if (sp < SP_FULL) begin
        npc_sel = NPC_CALL;
        push    = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end else if (branch_en && flag_q) begin
      npc_sel = rel_mode ? NPC_REL : NPC_ABS;
    end
  end

  // Next-PC multiplexer driven by the decoded source.
  always_comb begin
    next_pc = pc_inc;
    case (npc_sel)
      NPC_INC:  next_pc = pc_inc;
      NPC_ABS:  next_pc = lut_target;
      NPC_REL:  next_pc = pc_rel;
      NPC_CALL: next_pc = lut_target;
      NPC_RET:  next_pc = stack_top;
      NPC_HOLD: next_pc = prog_ctr;
      NPC_ZERO: next_pc = '0;
      default:  next_pc = pc_inc;
    endcase
  end

  // Architectural state: PC, stack pointer, flag, done latch, error latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prog_ctr  <= '0;
      sp        <= '0;
      flag_q    <= 1'b0;
      done_q    <= 1'b0;
      stack_err <= 1'b0;
    end else begin
      prog_ctr <= next_pc;
      if (init) begin
        sp        <= '0;
        flag_q    <= 1'b0;
        done_q    <= 1'b0;
        stack_err <= 1'b0;
      end else begin
        done_q <= done;
        if (push) begin
          sp <= sp + SPW'(1);
        end else if (pop) begin
          sp <= sp - SPW'(1);
        end
        if (err_set) begin
          stack_err <= 1'b1;
        end
        if (flag_load) begin
          flag_q <= flag_in;
        end
      end
    end
  end

  // Return-address storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[push_idx] <= pc_inc;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Directed-vector bench for fetch_ctrl with an expectation queue
//               drained by an independent monitor on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

  localparam logic [5:0] IDX_M2  = 6'd1;   // -2
  localparam logic [5:0] IDX_40  = 6'd2;   // 40
  localparam logic [5:0] IDX_245 = 6'd4;   // 245
  localparam logic [5:0] IDX_100 = 6'd6;   // 100

  logic        clk = 1'b0;
  logic        reset, init, stall, branch_en, rel_mode, call, ret;
  logic [5:0]  lut_idx;
  logic        flag_we, flag_in;
  logic [11:0] prog_ctr;
  logic        flag_q, done, stack_err;

  logic        reset4;
  logic        zero4 = 1'b0;
  logic [5:0]  idx4  = 6'd0;
  logic [3:0]  pc4;
  logic        flag4, done4, err4;

  typedef struct {
    string nm;
    int    unit;
    int    pc;
    logic  dn;
    logic  er;
    logic  fl;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .init(init), .stall(stall),
    .branch_en(branch_en), .rel_mode(rel_mode), .call(call), .ret(ret),
    .lut_idx(lut_idx), .flag_we(flag_we), .flag_in(flag_in),
    .prog_ctr(prog_ctr), .flag_q(flag_q), .done(done), .stack_err(stack_err)
  );

  fetch_ctrl #(.D(4)) dut4 (
    .clk(clk), .reset(reset4), .init(zero4), .stall(zero4),
    .branch_en(zero4), .rel_mode(zero4), .call(zero4), .ret(zero4),
    .lut_idx(idx4), .flag_we(zero4), .flag_in(zero4),
    .prog_ctr(pc4), .flag_q(flag4), .done(done4), .stack_err(err4)
  );

  task automatic push_exp(input string nm, input int unit, input int pc,
                          input logic dn, input logic er, input logic fl);
    exp_t e;
    e.nm = nm; e.unit = unit; e.pc = pc; e.dn = dn; e.er = er; e.fl = fl;
    q.push_back(e);
  endtask

  // b=branch_en r=rel_mode c=call t=ret st=stall in=init
  task automatic drive(input logic b, input logic r, input logic c, input logic t,
                       input logic [5:0] idx, input logic fwe, input logic fin,
                       input logic st, input logic in);
    branch_en = b; rel_mode = r; call = c; ret = t; lut_idx = idx;
    flag_we = fwe; flag_in = fin; stall = st; init = in;
  endtask

  task automatic step(input string nm, input bit chk, input int pc,
                      input logic dn, input logic er, input logic fl);
    @(posedge clk); #1;
    if (chk) push_exp(nm, 0, pc, dn, er, fl);
    @(negedge clk); #1;
  endtask

  task automatic step4(input string nm, input bit chk, input int pc);
    @(posedge clk); #1;
    if (chk) push_exp(nm, 1, pc, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        exp_t e;
        int   apc;
        logic adn, aer, afl;
        e = q.pop_front();
        if (e.unit == 0) begin
          apc = int'(prog_ctr); adn = done;  aer = stack_err; afl = flag_q;
        end else begin
          apc = int'(pc4);      adn = done4; aer = err4;      afl = flag4;
        end
        total++;
        if (apc != e.pc || adn !== e.dn || aer !== e.er || afl !== e.fl) begin
          bad++;
          $display("FAIL %s: got pc=%0d done=%0b err=%0b flag=%0b, want pc=%0d done=%0b err=%0b flag=%0b",
                   e.nm, apc, adn, aer, afl, e.pc, e.dn, e.er, e.fl);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset  = 1'b1;
    reset4 = 1'b1;
    drive(0, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    #1 push_exp("reset", 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    reset = 1'b0;

    // Free-running increment.
    for (int i = 1; i <= 5; i++) step("inc", 1, i, 0, 0, 0);

    // Conditional branches use the registered flag.
    drive(0, 0, 0, 0, 6'd0, 0, 0, 0, 1); step("init", 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) step("inc2", 1, i, 0, 0, 0);
    drive(0, 0, 0, 0, 6'd0, 1, 1, 0, 0);     step("flag_set", 1, 4, 0, 0, 1);
    drive(1, 1, 0, 0, IDX_M2, 0, 0, 0, 0);   step("br_rel_taken", 1, 2, 0, 0, 1);
    drive(0, 0, 0, 0, 6'd0, 1, 0, 0, 0);     step("flag_clr", 1, 3, 0, 0, 0);
    drive(0, 0, 0, 0, 6'd0, 0, 0, 0, 0);     step("inc3", 1, 4, 0, 0, 0);
    drive(1, 1, 0, 0, IDX_M2, 0, 1, 0, 0);   step("br_not_taken", 1, 5, 0, 0, 0);
    drive(0, 0, 0, 0, 6'd0, 1, 1, 0, 0);     step("flag_set2", 1, 6, 0, 0, 1);
    drive(1, 0, 0, 0, IDX_100, 0, 0, 0, 0);  step("br_abs", 1, 100, 0, 0, 1);

    // Fill the return stack with 101,42,43,44 then overflow.
    drive(0, 0, 1, 0, IDX_40, 0, 0, 0, 0);   step("call1", 1, 40, 0, 0, 1);
    drive(0, 0, 0, 0, 6'd0, 0, 0, 0, 0);     step("", 0, 41, 0, 0, 1);
    drive(0, 0, 1, 0, IDX_40, 0, 0, 0, 0);   step("call2", 1, 40, 0, 0, 1);
    drive(0, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    step("", 0, 41, 0, 0, 1); step("", 0, 42, 0, 0, 1);
    drive(0, 0, 1, 0, IDX_40, 0, 0, 0, 0);   step("call3", 1, 40, 0, 0, 1);
    drive(0, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    step("", 0, 41, 0, 0, 1); step("", 0, 42, 0, 0, 1); step("", 0, 43, 0, 0, 1);
    drive(0, 0, 1, 0, IDX_40, 0, 0, 0, 0);   step("call4", 1, 40, 0, 0, 1);
    drive(1, 1, 1, 0, IDX_40, 0, 0, 0, 0);   step("call_full", 1, 41, 0, 1, 1);
    drive(0, 0, 0, 1, 6'd0, 0, 0, 0, 0);
    step("ret1", 1, 44, 0, 1, 1);
    step("ret2", 1, 43, 0, 1, 1);
    step("ret3", 1, 42, 0, 1, 1);
    step("ret4", 1, 101, 0, 1, 1);
    step("ret_empty", 1, 102, 0, 1, 1);

    // call and ret together leave the stack untouched.
    drive(0, 0, 0, 0, 6'd0, 0, 0, 0, 1);     step("init_cr", 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, IDX_40, 0, 0, 0, 0);   step("cr_push", 1, 40, 0, 0, 0);
    drive(0, 0, 1, 1, IDX_40, 0, 0, 0, 0);   step("call_ret", 1, 41, 0, 1, 0);
    drive(0, 0, 0, 1, 6'd0, 0, 0, 0, 0);     step("ret_after_cr", 1, 1, 0, 1, 0);

    // Stall freezes everything, including error reporting.
    drive(0, 0, 0, 0, 6'd0, 0, 0, 0, 1);     step("init_st", 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, IDX_40, 1, 1, 1, 0);
    step("stall1", 1, 0, 0, 0, 0);
    step("stall2", 1, 0, 0, 0, 0);
    drive(0, 0, 1, 1, IDX_40, 1, 1, 1, 0);   step("stall3", 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, IDX_40, 0, 0, 0, 0);   step("stall_rel_call", 1, 40, 0, 0, 0);
    drive(0, 0, 0, 1, 6'd0, 0, 0, 0, 0);
    step("stall_ret", 1, 1, 0, 0, 0);
    step("stall_ret_empty", 1, 2, 0, 1, 0);

    // Run to DONE_PC and stay there.
    drive(0, 0, 0, 0, 6'd0, 0, 0, 0, 1);     step("init_dn", 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 6'd0, 1, 1, 0, 0);     step("dn_flag", 1, 1, 0, 0, 1);
    drive(1, 0, 0, 0, IDX_245, 0, 0, 0, 0);  step("dn_jump", 1, 245, 0, 0, 1);
    drive(0, 0, 0, 0, 6'd0, 0, 0, 0, 0);
    for (int i = 246; i <= 249; i++) step("dn_inc", 1, i, 0, 0, 1);
    step("done_hit", 1, 250, 1, 0, 1);
    drive(1, 0, 1, 0, IDX_100, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step("done_hold", 1, 250, 1, 0, 1);
    drive(0, 0, 0, 0, 6'd0, 0, 0, 0, 1);     step("done_init", 1, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a call sequence.
    drive(0, 0, 1, 0, IDX_40, 0, 0, 0, 0);   step("pre_rst_call", 1, 40, 0, 0, 0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1 push_exp("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    drive(0, 0, 1, 0, IDX_40, 0, 0, 1, 0);
    @(negedge clk); #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 6'd0, 0, 0, 0, 0);     step("post_rst", 1, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 6'd0, 0, 0, 0, 0);     step("post_rst_ret", 1, 2, 0, 1, 0);
    drive(0, 0, 0, 0, 6'd0, 0, 0, 0, 0);

    // Narrow instance: wrap from 15 to 0, then async reset between edges.
    reset4 = 1'b0;
    for (int i = 1; i <= 15; i++) step4("d4_inc15", (i == 15), i);
    step4("d4_wrap", 1, 0);
    step4("d4_one", 1, 1);
    @(posedge clk); #3;
    reset4 = 1'b1;
    #1 push_exp("d4_async", 1, 0, 0, 0, 0);
    @(negedge clk); #1;

    @(negedge clk); #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter D, default 12: program counter width in bits.
REQ-002 Parameter LW, default 6: branch-target LUT index width; the LUT has 2**LW entries.
REQ-003 Parameter SD, default 4: return-stack depth in entries; minimum 1.
REQ-004 Parameter DONE_PC, default 250: PC value that terminates the program.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 init  in  1  synchronous program restart.
REQ-008 stall  in  1  freezes PC, stack and flag for the cycle.
REQ-009 branch_en  in  1  conditional branch request for the current instruction.
REQ-010 rel_mode  in  1  0 = absolute target, 1 = PC-relative target.
REQ-011 call  in  1  subroutine call request.
REQ-012 ret  in  1  subroutine return request.
REQ-013 lut_idx  in  LW  LUT index taken from the machine code.
REQ-014 flag_we  in  1  flag register write enable.
REQ-015 flag_in  in  1  zero flag from the ALU.
REQ-016 prog_ctr  out  D  current instruction address.
REQ-017 flag_q  out  1  registered zero flag.
REQ-018 done  out  1  program finished, sticky.
REQ-019 stack_err  out  1  sticky overflow, underflow or illegal-combination error.

Function
REQ-020 Per-cycle priority SHALL be: init > done > stall > (call&ret) > ret > call > taken branch > increment.
REQ-021 init SHALL set PC=0, empty the stack, and clear done, stack_err and flag_q on the next edge.
REQ-022 Increment SHALL be PC+1 modulo 2**D, so 2**D-1 wraps to 0.
REQ-023 A branch SHALL be taken iff branch_en=1 and flag_q=1, using the flag registered in a prior cycle, not flag_in.
REQ-024 When taken with rel_mode=0, the next PC SHALL be the LUT entry.
REQ-025 When taken with rel_mode=1, the next PC SHALL be PC plus the LUT entry interpreted as D-bit two's complement, modulo 2**D.
REQ-026 A call with the stack not full SHALL push PC+1 and load the LUT entry as an absolute target, regardless of rel_mode.
REQ-027 A call with the stack full SHALL not push, SHALL set stack_err, and SHALL increment the PC.
REQ-028 A ret with the stack not empty SHALL pop and load the top entry into the PC.
REQ-029 A ret with the stack empty SHALL set stack_err and increment the PC.
REQ-030 call and ret asserted together SHALL set stack_err, change no stack state, and increment the PC.
REQ-031 flag_q SHALL load flag_in on an edge where flag_we=1 and stall=0; otherwise it SHALL hold.
REQ-032 done SHALL assert combinationally when prog_ctr==DONE_PC and SHALL remain 1 until init or reset.
REQ-033 While done=1, PC, stack and flag SHALL be frozen.
REQ-034 stall=1 SHALL hold all state; stall SHALL NOT set stack_err.
REQ-035 Next-PC selection SHALL be combinational; PC update latency is one cycle.

Reset
REQ-036 Asserting reset SHALL immediately set prog_ctr=0, stack pointer=0, flag_q=0, done=0 and stack_err=0, independent of clk.
REQ-037 Reset asserted mid-call or mid-stall SHALL discard all pending requests; the first edge after release SHALL execute from PC 0.
REQ-038 Stack storage contents need no reset; only the pointer is reset.

Structure
REQ-039 Package fetch_pkg SHALL hold the default D, LW, SD and DONE_PC constants, a next-PC-source enum {NPC_INC, NPC_ABS, NPC_REL, NPC_CALL, NPC_RET, NPC_HOLD, NPC_ZERO}, and the LUT initial-contents constant array.
REQ-040 Sub-module fetch_lut SHALL be the combinational index-to-D-bit-target table, parametrised by D and LW.
REQ-041 The return stack SHALL be implemented inside fetch_ctrl as a register array with a pointer of width clog2(SD+1).

Verification
REQ-042 Reset, then 5 edges with no requests -> prog_ctr steps 0,1,2,3,4,5; done=0.
REQ-043 flag_we=1, flag_in=1 at PC 3; next cycle branch_en=1, rel_mode=1, LUT entry=-2 -> PC 4 goes to 2. Repeat with flag_q=0 -> PC goes to 5.
REQ-044 SD=4: issue 5 calls to LUT entry 40 -> first 4 push the return addresses, 5th sets stack_err=1 and increments PC. Then 4 rets -> PC returns LIFO; a 5th ret -> stack_err stays 1, PC+1.
REQ-045 Run to PC 250 -> done=1 and PC held at 250 for 10 cycles with branch and call asserted; init -> PC=0, done=0.
REQ-046 stall=1 for 3 cycles with call asserted -> PC, stack and flag unchanged; stall released -> call executes once.
REQ-047 D=4, run from PC 15 -> wraps to 0; assert reset asynchronously between edges -> prog_ctr=0 before the next edge.
